// File: rtl/fetch_aligner.sv
// Fetch sequencer and halfword aligner between instruction memory and the decompressor:
// keeps up to DEPTH words in flight or buffered and emits one 16/32-bit instruction per cycle.
module fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_compressed
);
    // Handshakes: a fetch is accepted on a cycle with mem_req && mem_gnt and answered in
    // order by mem_rvalid; an instruction moves on a cycle with out_valid && out_ready, and
    // out_* stay stable while out_valid && !out_ready.

    localparam int unsigned   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   CW       = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW:0]   DEPTH_W  = (CW+1)'(DEPTH);

    logic [31:0]   q_mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, n_ptr;
    logic [CW-1:0] q_count, outstanding, discard, outstanding_nxt;
    logic [31:0]   fetch_addr, issue_pc;
    logic          started;

    logic          grant, push, pop, offset, is32, can_extract, load_en, do_extract;
    logic [CW:0]   avail;
    logic [31:0]   h_word, ext_instr, pc_step;
    logic [15:0]   n_half;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign mem_req  = started && !flush &&
                      (({1'b0, outstanding} + {1'b0, q_count}) < DEPTH_W);
    assign mem_addr = fetch_addr;

    // A word arriving this cycle is visible to extraction as if it were already queued.
    always_comb begin
        grant       = mem_req && mem_gnt;
        push        = mem_rvalid && (discard == '0) && !flush;
        avail       = {1'b0, q_count} + {{CW{1'b0}}, push};
        n_ptr       = ptr_inc(rd_ptr);
        h_word      = (q_count != '0) ? q_mem[rd_ptr] : mem_rdata;
        n_half      = (q_count > CW'(1)) ? q_mem[n_ptr][15:0] : mem_rdata[15:0];
        offset      = issue_pc[1];
        is32        = offset ? (h_word[17:16] == 2'b11) : (h_word[1:0] == 2'b11);
        can_extract = (offset && is32) ? (avail >= (CW+1)'(2)) : (avail != '0);
        load_en     = !out_valid || out_ready;
        do_extract  = can_extract && load_en && !flush;
        pop         = do_extract && (offset || is32);
        pc_step     = is32 ? 32'd4 : 32'd2;
        case ({offset, is32})
            2'b00:   ext_instr = {16'h0, h_word[15:0]};
            2'b01:   ext_instr = h_word;
            2'b10:   ext_instr = {16'h0, h_word[31:16]};
            default: ext_instr = {n_half, h_word[31:16]};
        endcase
        outstanding_nxt = outstanding + CW'(grant) - CW'(mem_rvalid);
    end

    always_ff @(posedge clk) begin
        if (push) q_mem[wr_ptr] <= mem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started        <= 1'b0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            q_count        <= '0;
            outstanding    <= '0;
            discard        <= '0;
            fetch_addr     <= RESET_PC & 32'hFFFF_FFFC;
            issue_pc       <= RESET_PC & 32'hFFFF_FFFE;
            out_valid      <= 1'b0;
            out_instr      <= '0;
            out_pc         <= '0;
            out_compressed <= 1'b0;
        end else begin
            started     <= 1'b1;
            outstanding <= outstanding_nxt;
            if (flush) begin
                // Every response still owed after this cycle belongs to the old stream.
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                q_count    <= '0;
                discard    <= outstanding_nxt;
                issue_pc   <= flush_pc & 32'hFFFF_FFFE;
                fetch_addr <= flush_pc & 32'hFFFF_FFFC;
                out_valid  <= 1'b0;
            end else begin
                if (mem_rvalid && (discard != '0)) discard <= discard - CW'(1);
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop) rd_ptr <= ptr_inc(rd_ptr);
                q_count <= q_count + CW'(push) - CW'(pop);
                if (grant) fetch_addr <= fetch_addr + 32'd4;
                if (do_extract) issue_pc <= issue_pc + pc_step;
                if (load_en) begin
                    out_valid <= do_extract;
                    if (do_extract) begin
                        out_instr      <= ext_instr;
                        out_pc         <= issue_pc;
                        out_compressed <= !is32;
                    end
                end
            end
        end
    end

    rvalid_has_outstanding: assert property (
        @(posedge clk) disable iff (!rst_n) !(mem_rvalid && (outstanding == '0)));

endmodule
